// File: rtl/freecell_if.sv
// Handshake bundle between a FreeCell player and the move engine.
// It carries deal loading, the move request and the move result.
interface freecell_if #(
   parameter int unsigned MC_W = 16
) ();
   logic            load_valid;
   logic [2:0]      load_col;
   logic [5:0]      load_card;
   logic            req_valid;
   logic            req_ready;
   logic [3:0]      req_src;
   logic [3:0]      req_dest;
   logic [3:0]      req_count;
   logic            done;
   logic [1:0]      status;
   logic [MC_W-1:0] move_count;
   logic            win;

   modport master (
      output load_valid, load_col, load_card, req_valid, req_src, req_dest, req_count,
      input  req_ready, done, status, move_count, win
   );

   modport slave (
      input  load_valid, load_col, load_card, req_valid, req_src, req_dest, req_count,
      output req_ready, done, status, move_count, win
   );
endinterface

// File: rtl/freecell_engine.sv
// Sequential FreeCell move engine that owns the tableau, free-cell and home storage.
// Supermoves are lifted into a run buffer one card per cycle, then placed or restored.
module freecell_engine #(
   parameter int unsigned NUM_TAB  = 8,
   parameter int unsigned NUM_FREE = 4,
   parameter int unsigned TAB_MAX  = 26,
   parameter int unsigned MAX_RUN  = 13,
   parameter int unsigned MC_W     = 16
) (
   input logic       clock,
   input logic       reset,
   freecell_if.slave bus
);
   localparam int unsigned LW = $clog2(TAB_MAX + 1);
   localparam int unsigned BW = $clog2(MAX_RUN + 1);
   localparam logic [7:0] TAB_OK  = 8'((1 << NUM_TAB) - 1);
   localparam logic [3:0] FREE_OK = 4'((1 << NUM_FREE) - 1);
   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_ILLEGAL = 2'b01;
   localparam logic [1:0] ST_ABORT   = 2'b10;

   typedef enum logic [2:0] {StIdle, StCheck, StLift, StPlace, StRestore, StDone} state_t;

   state_t          state_q;
   logic [5:0]      tab_q       [8][TAB_MAX];
   logic [LW-1:0]   tab_len_q   [8];
   logic [5:0]      free_card_q [4];
   logic [3:0]      free_full_q;
   logic [3:0]      home_cnt_q  [4];
   logic [5:0]      run_q       [MAX_RUN];
   logic [BW-1:0]   run_len_q;
   logic [3:0]      src_q, dest_q, cnt_q;
   logic            done_q, win_q;
   logic [1:0]      status_q;
   logic [MC_W-1:0] mc_q;

   logic          src_tab, src_free, dst_tab, dst_free;
   logic [2:0]    sc, dc;
   logic [1:0]    sf, df;
   logic [LW-1:0] src_len, dst_len, src_ptr, dst_ptr;
   logic [BW-1:0] run_ptr;
   logic [5:0]    src_top, dst_top, run_top;
   logic          src_idx_ok, dst_idx_ok, illegal, seq_ok, last_lift, fit, home_full;
   int unsigned   free_empty, tab_empty, capacity;

   // True when upper may sit on lower: one rank below, opposite colour.
   function automatic logic stacks_on(input logic [5:0] lower, input logic [5:0] upper);
      return (lower[3:0] == upper[3:0] + 4'd1) && ((lower[5] ^ lower[4]) != (upper[5] ^ upper[4]));
   endfunction

   always_comb begin
      sc       = src_q[2:0];
      sf       = src_q[1:0];
      dc       = dest_q[2:0];
      df       = dest_q[1:0];
      src_tab  = !src_q[3];
      src_free = (src_q[3:2] == 2'b10);
      dst_tab  = !dest_q[3];
      dst_free = (dest_q[3:2] == 2'b10);

      src_idx_ok = src_tab ? TAB_OK[sc] : (src_free ? FREE_OK[sf] : 1'b0);
      dst_idx_ok = dst_tab ? TAB_OK[dc] : (dst_free ? FREE_OK[df] : 1'b1);

      src_len = src_tab ? tab_len_q[sc] : (src_free ? LW'(free_full_q[sf]) : '0);
      dst_len = tab_len_q[dc];
      src_ptr = src_len - LW'(1);
      if (src_len == '0) src_ptr = '0;
      dst_ptr = dst_len - LW'(1);
      if (dst_len == '0) dst_ptr = '0;
      run_ptr = run_len_q - BW'(1);
      if (run_len_q == '0) run_ptr = '0;

      src_top = src_tab ? tab_q[sc][src_ptr] : free_card_q[sf];
      dst_top = tab_q[dc][dst_ptr];
      run_top = run_q[run_ptr];

      free_empty = 0;
      for (int i = 0; i < int'(NUM_FREE); i++) begin
         if (!free_full_q[i]) free_empty++;
      end
      tab_empty = 0;
      for (int i = 0; i < int'(NUM_TAB); i++) begin
         if (tab_len_q[i] == '0 && !(dst_tab && dc == 3'(i))) tab_empty++;
      end
      capacity = (free_empty + 32'd1) << tab_empty;

      illegal = !src_idx_ok || (src_len == '0) || (src_q == dest_q) || !dst_idx_ok ||
                (cnt_q == 4'd0) || (32'(cnt_q) > MAX_RUN) ||
                ((cnt_q > 4'd1) && (!src_tab || !dst_tab)) ||
                (dst_free && free_full_q[df]) || (32'(cnt_q) > capacity);

      seq_ok    = (run_len_q == '0) || stacks_on(src_top, run_top);
      last_lift = (32'(run_len_q) + 32'd1) == 32'(cnt_q);

      // The card being lifted on the last LIFT cycle becomes the run base.
      if (dst_tab) begin
         fit = ((dst_len == '0) || stacks_on(dst_top, src_top)) &&
               (32'(dst_len) + 32'(cnt_q) <= TAB_MAX);
      end else if (dst_free) begin
         fit = !free_full_q[df];
      end else begin
         fit = (home_cnt_q[src_top[5:4]] == src_top[3:0] - 4'd1);
      end

      home_full = (home_cnt_q[0] == 4'd13) && (home_cnt_q[1] == 4'd13) &&
                  (home_cnt_q[2] == 4'd13) && (home_cnt_q[3] == 4'd13);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         for (int i = 0; i < 8; i++) tab_len_q[i] <= '0;
         for (int i = 0; i < 4; i++) home_cnt_q[i] <= '0;
         free_full_q <= '0;
         run_len_q   <= '0;
         src_q       <= '0;
         dest_q      <= '0;
         cnt_q       <= '0;
         done_q      <= 1'b0;
         status_q    <= ST_OK;
         mc_q        <= '0;
         win_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         win_q  <= home_full;
         unique case (state_q)
            StIdle: begin
               if (bus.load_valid) begin
                  if (TAB_OK[bus.load_col] && (32'(tab_len_q[bus.load_col]) < TAB_MAX)) begin
                     tab_q[bus.load_col][tab_len_q[bus.load_col]] <= bus.load_card;
                     tab_len_q[bus.load_col] <= tab_len_q[bus.load_col] + LW'(1);
                  end
               end else if (bus.req_valid) begin
                  src_q   <= bus.req_src;
                  dest_q  <= bus.req_dest;
                  cnt_q   <= bus.req_count;
                  state_q <= StCheck;
               end
            end
            StCheck: begin
               run_len_q <= '0;
               if (illegal) begin
                  status_q <= ST_ILLEGAL;
                  state_q  <= StDone;
               end else begin
                  state_q <= StLift;
               end
            end
            StLift: begin
               if (src_len == '0 || !seq_ok) begin
                  status_q <= ST_ABORT;
                  state_q  <= StRestore;
               end else begin
                  run_q[run_len_q] <= src_top;
                  run_len_q <= run_len_q + BW'(1);
                  if (src_tab) tab_len_q[sc] <= tab_len_q[sc] - LW'(1);
                  else         free_full_q[sf] <= 1'b0;
                  if (last_lift) begin
                     if (fit) begin
                        state_q <= StPlace;
                     end else begin
                        status_q <= ST_ABORT;
                        state_q  <= StRestore;
                     end
                  end
               end
            end
            StPlace: begin
               run_len_q <= run_len_q - BW'(1);
               if (dst_tab) begin
                  tab_q[dc][dst_len] <= run_top;
                  tab_len_q[dc] <= dst_len + LW'(1);
               end else if (dst_free) begin
                  free_card_q[df] <= run_top;
                  free_full_q[df] <= 1'b1;
               end else begin
                  home_cnt_q[run_top[5:4]] <= home_cnt_q[run_top[5:4]] + 4'd1;
               end
               if (run_len_q == BW'(1)) begin
                  status_q <= ST_OK;
                  state_q  <= StDone;
               end
            end
            StRestore: begin
               // Lifted cards were never overwritten, so pushing back rebuilds the column exactly.
               if (run_len_q != '0) begin
                  run_len_q <= run_len_q - BW'(1);
                  if (src_tab) begin
                     tab_q[sc][src_len] <= run_top;
                     tab_len_q[sc] <= src_len + LW'(1);
                  end else begin
                     free_card_q[sf] <= run_top;
                     free_full_q[sf] <= 1'b1;
                  end
               end
               if (run_len_q <= BW'(1)) state_q <= StDone;
            end
            StDone: begin
               done_q <= 1'b1;
               if (status_q == ST_OK && mc_q != '1) mc_q <= mc_q + MC_W'(1);
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.req_ready  = (state_q == StIdle) && !bus.load_valid;
   assign bus.done       = done_q;
   assign bus.status     = status_q;
   assign bus.move_count = mc_q;
   assign bus.win        = win_q;
endmodule
